// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator keypad front end.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int KEY_W = 4;

    localparam logic [3:0] COL0 = 4'b0001;
    localparam logic [3:0] COL1 = 4'b0010;
    localparam logic [3:0] COL2 = 4'b0100;
    localparam logic [3:0] COL3 = 4'b1000;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_ONE   = 2'd1,
        RES_MULTI = 2'd2
    } sweep_res_e;

    typedef struct packed {
        sweep_res_e       res;
        logic [KEY_W-1:0] code;
    } sweep_t;

    // Bit i of the sweep vector is key code i, so a lone set bit's index is its code.
    // An empty sweep always reports code 0 so that two empty sweeps compare equal.
    function automatic sweep_t classify_sweep(input logic [15:0] bits);
        sweep_t r;
        int     n;
        r.res  = RES_NONE;
        r.code = '0;
        n      = 0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                n      = n + 1;
                r.code = KEY_W'(i);
            end
        end
        if (n == 1) begin
            r.res = RES_ONE;
        end else if (n > 1) begin
            r.res = RES_MULTI;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick_gen
// Description : Free-running prescaler emitting a one-clock tick every SCAN_DIV clk.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int               CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad column scanner with row synchronizer, sweep
//               classification and sweep-count debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_value,
    output logic             key_valid
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN_C0 = 2'd0,
        SCAN_C1 = 2'd1,
        SCAN_C2 = 2'd2,
        SCAN_C3 = 2'd3
    } scan_state_e;

    logic             w_tick;
    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    scan_state_e      r_state;
    logic [11:0]      r_acc;
    sweep_t           r_prev;
    logic [CNT_W-1:0] r_stable_cnt;
    logic             r_restore;

    sweep_t           w_sweep;
    logic             w_same;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_commit;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Column 3 is classified straight from the synchronizer, on the tick that ends it.
    assign w_sweep = classify_sweep({r_row_sync, r_acc});
    assign w_same  = (w_sweep == r_prev);

    always_comb begin
        w_next_cnt = CNT_W'(1);
        if (w_sweep.res == RES_MULTI) begin
            w_next_cnt = '0;
        end else if (w_same) begin
            w_next_cnt = (r_stable_cnt == CNT_SAT) ? CNT_SAT : r_stable_cnt + CNT_W'(1);
        end
    end

    // Fire only on entry into saturation, never while a run stays saturated.
    assign w_commit = (w_next_cnt == CNT_SAT) && !(w_same && (r_stable_cnt == CNT_SAT));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= SCAN_C0;
            col          <= COL0;
            key_value    <= '0;
            key_valid    <= 1'b0;
            r_acc        <= '0;
            r_prev       <= '{res: RES_NONE, code: '0};
            r_stable_cnt <= '0;
            r_restore    <= 1'b0;
        end else begin
            if (r_restore) begin
                key_valid <= 1'b1;
                r_restore <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    SCAN_C0: begin
                        r_state     <= SCAN_C1;
                        col         <= COL1;
                        r_acc[3:0]  <= r_row_sync;
                    end
                    SCAN_C1: begin
                        r_state     <= SCAN_C2;
                        col         <= COL2;
                        r_acc[7:4]  <= r_row_sync;
                    end
                    SCAN_C2: begin
                        r_state     <= SCAN_C3;
                        col         <= COL3;
                        r_acc[11:8] <= r_row_sync;
                    end
                    SCAN_C3: begin
                        r_state      <= SCAN_C0;
                        col          <= COL0;
                        r_acc        <= '0;
                        r_prev       <= w_sweep;
                        r_stable_cnt <= w_next_cnt;
                        if (w_commit) begin
                            if (w_sweep.res == RES_ONE) begin
                                if (!key_valid) begin
                                    key_value <= w_sweep.code;
                                    key_valid <= 1'b1;
                                end else if (w_sweep.code != key_value) begin
                                    // One-clock low gap gives the edge detector a fresh press.
                                    key_value <= w_sweep.code;
                                    key_valid <= 1'b0;
                                    r_restore <= 1'b1;
                                end
                            end else begin
                                key_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= SCAN_C0;
                        col     <= COL0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Keypad model: a held key code {c,r} shorts column c to row r.
    always_comb begin
        row = '0;
        for (int c = 0; c < 4; c++) begin
            if (col[c]) row = row | keys[c*4 +: 4];
        end
    end

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .row       (row),
        .col       (col),
        .key_value (key_value),
        .key_valid (key_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input logic exp, input int budget, input string tag);
        int n = 0;
        while (key_valid !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, key_valid}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int         cnt;
        int         low;
        logic       done;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b0001);
        check("rst_valid", key_valid, 1'b0);
        check("rst_value", key_value, 4'd0);

        // Column rotation: step lands on the 4th clk after release
        reset_p = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if ((k % 4) == 0 || (k % 4) == 3) begin
                exp_col = 4'b0001;
                exp_col = exp_col << ((k / 4) % 4);
                check($sformatf("col_rot_%0d", k), col, exp_col);
            end
        end

        // Press key 9 (col 2, row 1)
        keys[9] = 1'b1;
        wait_valid(1'b1, 67, "press_valid");
        check("press_value", key_value, 4'd9);
        cnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (!key_valid) cnt++;
        end
        check("press_hold_drops", cnt, 0);

        // Release
        keys = '0;
        wait_valid(1'b0, 67, "release_valid");
        check("release_value", key_value, 4'd9);

        // Bounce: toggle every 5 clk for 48 clk, then hold
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if ((i % 5) == 0) keys[9] = ~keys[9];
            @(negedge clk);
            if (key_valid) cnt++;
        end
        check("bounce_quiet", cnt, 0);
        keys[9] = 1'b1;
        wait_valid(1'b1, 67, "bounce_settle_valid");
        check("bounce_settle_value", key_value, 4'd9);
        keys = '0;
        wait_valid(1'b0, 67, "bounce_release_valid");

        // Two keys together never commit
        keys[9] = 1'b1;
        keys[6] = 1'b1;
        cnt = 0;
        repeat (96) begin
            @(negedge clk);
            if (key_valid !== 1'b0 || key_value !== 4'd9) cnt++;
        end
        check("multi_no_change", cnt, 0);
        keys = '0;
        repeat (64) @(negedge clk);
        check("multi_release_valid", key_valid, 1'b0);

        // Direct change 9 -> 6: exactly one low clk
        keys[9] = 1'b1;
        wait_valid(1'b1, 67, "chg_first_valid");
        check("chg_first_value", key_value, 4'd9);
        keys = '0;
        keys[6] = 1'b1;
        low  = 0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (!key_valid) low++;
            else if (low > 0) done = 1'b1;
        end
        check("chg_low_width", low, 1);
        check("chg_value", key_value, 4'd6);
        check("chg_valid_back", key_valid, 1'b1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 reset_p = 1'b1;
        #1;
        check("async_rst_col", col, 4'b0001);
        check("async_rst_valid", key_valid, 1'b0);
        check("async_rst_value", key_value, 4'd0);

        // Reset mid-debounce restarts the count
        keys = '0;
        keys[9] = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_pre_valid", key_valid, 1'b0);
        @(posedge clk);
        #2 reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        cnt = 0;
        while (key_valid !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_rst_latency", cnt, 48);
        check("mid_rst_value", key_value, 4'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
